// File: rtl/sc_window_decoder_pkg.sv
// Shared types and result arithmetic for the stochastic window decoder.
// The bipolar output option is selected in the top by SC_WINDOW_DECODER_BIPOLAR_EN.
package sc_window_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  localparam int unsigned MAX_WIDTH = 32;

  // An all-ones window would overflow the code by one, so it saturates to the top code.
  function automatic logic [MAX_WIDTH-1:0] sat_code(input logic [MAX_WIDTH:0] ones,
                                                     input int unsigned width);
    logic [MAX_WIDTH:0] full;
    full = 33'd1 << width;
    if (ones == full) begin
      sat_code = 32'(full - 33'd1);
    end else begin
      sat_code = 32'(ones & (full - 33'd1));
    end
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// WIDTH+1-bit up-counter with synchronous clear and count enable.
// Holds the number of 1s seen so far in the current window.
module sc_ones_counter #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  output logic [WIDTH:0] count
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/sc_window_decoder.sv
// Stochastic-to-binary decoder: counts 1s over 2^WIDTH accepted bits.
// Define SC_WINDOW_DECODER_BIPOLAR_EN for a bipolar two's-complement output code.
module sc_window_decoder
  import sc_window_decoder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [WIDTH-1:0] BIT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] bit_cnt;
  logic [WIDTH:0]   ones_cnt;
  logic [WIDTH:0]   ones_cnt_next;
  logic             accept;
  logic             handshake;
  logic             clr;
  logic             ones_en;
  logic [WIDTH-1:0] u_next;
  logic [WIDTH-1:0] code_next;

  assign in_ready  = (state == ACC);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign clr       = start && ((state == IDLE) || ((state == DONE) && handshake));
  assign ones_en   = accept && in_bit;

  // The last bit of the window is folded in here so the result registers on the same edge.
  assign ones_cnt_next = ones_cnt + {{WIDTH{1'b0}}, ones_en};
  assign u_next        = WIDTH'(sat_code(33'(ones_cnt_next), WIDTH));

`ifdef SC_WINDOW_DECODER_BIPOLAR_EN
  assign code_next = u_next ^ {1'b1, {(WIDTH-1){1'b0}}};
`else
  assign code_next = u_next;
`endif

  sc_ones_counter #(
    .WIDTH(WIDTH)
  ) u_ones_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (ones_en),
    .count(ones_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ACC;
            bit_cnt <= '0;
          end
        end
        ACC: begin
          if (accept) begin
            bit_cnt <= bit_cnt + BIT_ONE;
            if (bit_cnt == '1) begin
              state     <= DONE;
              out_data  <= code_next;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (handshake) begin
            out_valid <= 1'b0;
            bit_cnt   <= '0;
            state     <= start ? ACC : IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
